stim_channel_sequencer: RTL

Sequences biphasic stimulation pulses across the eight electrode channels of the stimulator by driving the 3-to-8 channel decoder's select and enable inputs. On each start command it walks every channel set in a latched mask, in ascending index order. For each channel it emits a cathodic phase, an interphase gap and an anodic phase, then reports completion. It sits between the stimulation command register block and the channel decoder, and is the only driver of the decoder's `Bin`/`Enable` inputs.

---
 rtl/stim_channel_sequencer_if.sv | 38 +++
 rtl/stim_channel_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/stim_channel_sequencer_if.sv
// Command/decoder bundle for stim_channel_sequencer.
// The master side is the stimulation command register block and the consumer of Bin/Enable.
// The slave side is the sequencer itself.
// STIM_SEQ_ABORT_EN adds the Abort command line.
interface stim_channel_sequencer_if #(
  parameter int PW_W = 8
);
  logic            Start;
  logic [7:0]      ChMask;
  logic [PW_W-1:0] PhaseWidth;
  logic [PW_W-1:0] GapWidth;
  logic [2:0]      Bin;
  logic            Enable;
  logic            PhaseSel;
  logic            Busy;
  logic            Done;
`ifdef STIM_SEQ_ABORT_EN
  logic            Abort;

  modport master (
    output Start, ChMask, PhaseWidth, GapWidth, Abort,
    input  Bin, Enable, PhaseSel, Busy, Done
  );
  modport slave (
    input  Start, ChMask, PhaseWidth, GapWidth, Abort,
    output Bin, Enable, PhaseSel, Busy, Done
  );
`else
  modport master (
    output Start, ChMask, PhaseWidth, GapWidth,
    input  Bin, Enable, PhaseSel, Busy, Done
  );
  modport slave (
    input  Start, ChMask, PhaseWidth, GapWidth,
    output Bin, Enable, PhaseSel, Busy, Done
  );
`endif
endinterface

// File: rtl/stim_channel_sequencer.sv
// Biphasic stimulation sequencer for eight electrode channels.
// It walks the latched channel mask from the lowest index to the highest.
// Each channel gets a cathodic phase, an optional interphase gap and an anodic phase.
// This block is the sole driver of the channel decoder's Bin/Enable inputs.
// Optional feature macro: STIM_SEQ_ABORT_EN adds an Abort input that returns to IDLE silently.
module stim_channel_sequencer #(
  parameter int PW_W = 8
) (
  input logic                   Clk,
  input logic                   Rst,
  stim_channel_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    PHASE1 = 3'd2,
    GAP    = 3'd3,
    PHASE2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_reg;
  logic [7:0]      mask_reg;
  logic [PW_W-1:0] pw_reg;
  logic [PW_W-1:0] gw_reg;
  logic [PW_W-1:0] cnt_reg;
  logic [2:0]      bin_reg;
  logic            enable_reg;
  logic            phase_sel_reg;
  logic            busy_reg;
  logic            done_reg;

  logic            found;
  logic [2:0]      low_idx;
  logic [PW_W-1:0] phase_load;
  logic            abort_req;

`ifdef STIM_SEQ_ABORT_EN
  assign abort_req = bus.Abort;
`else
  assign abort_req = 1'b0;
`endif

  // A phase width of 0 behaves as a one-cycle phase.
  assign phase_load = (pw_reg == '0) ? '0 : pw_reg - 1'b1;

  // Find the lowest set bit of the working mask.
  // The loop scans downward, so the last hit is the lowest index.
  always_comb begin
    found   = 1'b0;
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) begin
        found   = 1'b1;
        low_idx = 3'(i);
      end
    end
  end

  // Sequencer FSM.
  // Outputs are registered so that they take their new values on the same edge as the state change.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= IDLE;
      mask_reg      <= '0;
      pw_reg        <= '0;
      gw_reg        <= '0;
      cnt_reg       <= '0;
      bin_reg       <= '0;
      enable_reg    <= 1'b0;
      phase_sel_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.Start && !abort_req) begin
            mask_reg  <= bus.ChMask;
            pw_reg    <= bus.PhaseWidth;
            gw_reg    <= bus.GapWidth;
            busy_reg  <= 1'b1;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (found) begin
            // Bin only ever moves here, while Enable is low.
            bin_reg       <= low_idx;
            cnt_reg       <= phase_load;
            enable_reg    <= 1'b1;
            phase_sel_reg <= 1'b0;
            state_reg     <= PHASE1;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
        end
        PHASE1: begin
          if (cnt_reg == '0) begin
            if (gw_reg != '0) begin
              cnt_reg    <= gw_reg - 1'b1;
              enable_reg <= 1'b0;
              state_reg  <= GAP;
            end else begin
              cnt_reg       <= phase_load;
              phase_sel_reg <= 1'b1;
              state_reg     <= PHASE2;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            cnt_reg       <= phase_load;
            enable_reg    <= 1'b1;
            phase_sel_reg <= 1'b1;
            state_reg     <= PHASE2;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        PHASE2: begin
          if (cnt_reg == '0) begin
            mask_reg[bin_reg] <= 1'b0;
            enable_reg        <= 1'b0;
            phase_sel_reg     <= 1'b0;
            state_reg         <= SCAN;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Abort overrides whatever the case statement chose.
      // It returns to IDLE quietly, with no Done pulse.
      if (abort_req && state_reg != IDLE) begin
        state_reg     <= IDLE;
        mask_reg      <= '0;
        cnt_reg       <= '0;
        enable_reg    <= 1'b0;
        phase_sel_reg <= 1'b0;
        busy_reg      <= 1'b0;
        done_reg      <= 1'b0;
      end
    end
  end

  assign bus.Bin      = bin_reg;
  assign bus.Enable   = enable_reg;
  assign bus.PhaseSel = phase_sel_reg;
  assign bus.Busy     = busy_reg;
  assign bus.Done     = done_reg;

endmodule
